// File: rtl/cpri_tx_packer.sv
// cpri_tx_packer: buffers per-symbol IQ payload and streams header plus payload to the CPRI framer
module cpri_tx_packer #(
    parameter int DATA_WIDTH   = 64,
    parameter int FIFO_AW      = 11,
    parameter int SYMB_LEN     = 1583,
    parameter int START_THRESH = 512,
    parameter int AFULL_MARGIN = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tvalid,
    input  logic                  i_tx_sop,
    input  logic                  i_tx_eop,
    input  logic [6:0]            i_slot_idx,
    input  logic [3:0]            i_symb_idx,
    input  logic [31:0]           i_fft_agc,
    output logic                  o_tready,
    input  logic                  i_cpri_ready,
    output logic [DATA_WIDTH-1:0] o_cpri_data,
    output logic                  o_cpri_vld,
    output logic                  o_cpri_sop,
    output logic                  o_cpri_eop,
    output logic                  o_underflow,
    output logic                  o_len_err,
    output logic [FIFO_AW:0]      o_fifo_level
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(SYMB_LEN + 1) + 1;
    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    logic [1:0] rst_sync_q;
    logic       rst_n;
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) rst_sync_q <= '0;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    assign rst_n = rst_sync_q[1];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [FIFO_AW:0]      lvl_q, lvl_d;
    logic [31:0]           agc_q [2], agc_d [2];
    logic [6:0]            slot_q [2], slot_d [2];
    logic [3:0]            symb_q [2], symb_d [2];
    logic [1:0]            done_q, done_d, hq_cnt_q, hq_cnt_d;
    logic                  hq_wp_q, hq_wp_d, hq_rp_q, hq_rp_d;
    logic                  in_sym_q, in_sym_d;
    logic [CW-1:0]         wcnt_q, wcnt_d, pay_q, pay_d;
    state_t                st_q, st_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  vld_q, vld_d, sop_q, sop_d, eop_q, eop_d;
    logic                  und_q, und_d, lerr_q, lerr_d;
    logic                  push, hq_push, hq_pop, fifo_pop, fifo_has;
    logic [FIFO_AW+1:0]    free;
    logic [DATA_WIDTH-1:0] fifo_word;

    assign push      = i_tvalid & o_tready;
    assign hq_push   = push & i_tx_sop;
    assign free      = (FIFO_AW+2)'(DEPTH) - (FIFO_AW+2)'(lvl_q);
    assign o_tready  = (free > (FIFO_AW+2)'(AFULL_MARGIN)) && (hq_cnt_q != 2'd2);
    assign fifo_has  = lvl_q != '0;
    assign fifo_word = fifo_has ? mem[rp_q] : '0;

    always_ff @(posedge i_clk)
        if (push) mem[wp_q] <= i_tx_data;

    always_comb begin
        agc_d    = agc_q;
        slot_d   = slot_q;
        symb_d   = symb_q;
        done_d   = done_q;
        hq_wp_d  = hq_wp_q;
        in_sym_d = in_sym_q;
        wcnt_d   = wcnt_q;
        st_d     = st_q;
        pay_d    = pay_q;
        data_d   = data_q;
        vld_d    = vld_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        und_d    = und_q;
        lerr_d   = lerr_q | (i_tvalid & ~o_tready);
        hq_pop   = 1'b0;
        fifo_pop = 1'b0;
        if (push) begin
            wcnt_d   = i_tx_sop ? CW'(1) : (&wcnt_q ? wcnt_q : wcnt_q + 1'b1);
            in_sym_d = (in_sym_q | i_tx_sop) & ~i_tx_eop;
            if (i_tx_sop) begin
                // a new sop while the previous symbol is still open closes it early
                if (in_sym_q) begin
                    lerr_d          = 1'b1;
                    done_d[~hq_wp_q] = 1'b1;
                end
                agc_d[hq_wp_q]  = i_fft_agc;
                slot_d[hq_wp_q] = i_slot_idx;
                symb_d[hq_wp_q] = i_symb_idx;
                done_d[hq_wp_q] = 1'b0;
                hq_wp_d         = ~hq_wp_q;
            end
            if (i_tx_eop) begin
                done_d[i_tx_sop ? hq_wp_q : ~hq_wp_q] = 1'b1;
                if (wcnt_d != CW'(SYMB_LEN)) lerr_d = 1'b1;
            end
        end
        if (st_q == IDLE) begin
            if (hq_cnt_q != 2'd0 && (done_q[hq_rp_q] || lvl_q >= (FIFO_AW+1)'(START_THRESH))) begin
                st_d   = HDR;
                vld_d  = 1'b1;
                sop_d  = 1'b1;
                data_d = {agc_q[hq_rp_q], 13'd0, slot_q[hq_rp_q], symb_q[hq_rp_q], 8'hA5};
            end
        end else if (i_cpri_ready) begin
            if (eop_q) begin
                st_d   = IDLE;
                vld_d  = 1'b0;
                eop_d  = 1'b0;
                data_d = '0;
            end else begin
                // output is registered, so the word is popped when it is loaded
                hq_pop   = st_q == HDR;
                st_d     = PAY;
                sop_d    = 1'b0;
                pay_d    = (st_q == HDR) ? '0 : pay_q + 1'b1;
                eop_d    = pay_d == CW'(SYMB_LEN - 1);
                fifo_pop = fifo_has;
                data_d   = fifo_word;
                und_d    = und_q | ~fifo_has;
            end
        end
        wp_d     = wp_q + FIFO_AW'(push);
        rp_d     = rp_q + FIFO_AW'(fifo_pop);
        lvl_d    = lvl_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(fifo_pop);
        hq_cnt_d = hq_cnt_q + {1'b0, hq_push} - {1'b0, hq_pop};
        hq_rp_d  = hq_rp_q ^ hq_pop;
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q     <= '0;
            rp_q     <= '0;
            lvl_q    <= '0;
            agc_q    <= '{default: '0};
            slot_q   <= '{default: '0};
            symb_q   <= '{default: '0};
            done_q   <= '0;
            hq_cnt_q <= '0;
            hq_wp_q  <= 1'b0;
            hq_rp_q  <= 1'b0;
            in_sym_q <= 1'b0;
            wcnt_q   <= '0;
            st_q     <= IDLE;
            pay_q    <= '0;
            data_q   <= '0;
            vld_q    <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            und_q    <= 1'b0;
            lerr_q   <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            lvl_q    <= lvl_d;
            agc_q    <= agc_d;
            slot_q   <= slot_d;
            symb_q   <= symb_d;
            done_q   <= done_d;
            hq_cnt_q <= hq_cnt_d;
            hq_wp_q  <= hq_wp_d;
            hq_rp_q  <= hq_rp_d;
            in_sym_q <= in_sym_d;
            wcnt_q   <= wcnt_d;
            st_q     <= st_d;
            pay_q    <= pay_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            und_q    <= und_d;
            lerr_q   <= lerr_d;
        end
    end

    assign o_cpri_data  = data_q;
    assign o_cpri_vld   = vld_q;
    assign o_cpri_sop   = sop_q;
    assign o_cpri_eop   = eop_q;
    assign o_underflow  = und_q;
    assign o_len_err    = lerr_q;
    assign o_fifo_level = lvl_q;
endmodule
